axi_wr_frontend: RTL

- AXI write-side slave front-end of the DDR2 controller; sits directly downstream of the interconnect AW/W/B channels.
- Accepts one write burst at a time: latches the AW command and forwards it as a single request to the command scheduler.
- Buffers W beats in a data FIFO drained by the data path, and returns the B response once the burst is fully absorbed.

---
 rtl/axi_wr_frontend_pkg.sv | 41 ++++
 rtl/axi_wr_frontend_if.sv | 78 +++++++
 rtl/axi_wr_frontend_fifo.sv | 57 +++++
 rtl/axi_wr_frontend.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/axi_wr_frontend_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared types and constants for the AXI write-side front-end of the DDR2
// controller.
//   resp_t          : AXI B-channel response codes
//   burst_t         : AXI burst type encodings
//   wr_fe_state_e   : front-end FSM states
//   DEF_*           : default widths used by the front-end and its interface
//   axsize_for()    : AXI size code of a full-width beat for a data width
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ID_WIDTH   = 4;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_fe_state_e;

    // A full-width beat transfers DATA_WIDTH/8 bytes, i.e. size = log2(bytes).
    function automatic logic [2:0] axsize_for(input int dataWidth);
        return 3'($clog2(dataWidth / 8));
    endfunction

endpackage

// File: rtl/axi_wr_frontend_if.sv
// ---------------------------------------------------------------------------
// axi_wr_frontend_if
// Bundles every handshake/bus signal of the write front-end:
//   AW channel  : awvalid/awready, awid, awaddr, awlen, awsize, awburst
//   W channel   : wvalid/wready, wid, wdata, wstrb, wlast
//   B channel   : bvalid/bready, bid, bresp
//   Scheduler   : req_valid/req_ready, req_id, req_addr, req_len
//   Data path   : wd_valid/wd_ready, wd_data, wd_strb, wd_last
// Modports:
//   slave  : the front-end's view (AXI slave, request/data source)
//   master : the surrounding environment's view
// ---------------------------------------------------------------------------
interface axi_wr_frontend_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
);

    logic                      awvalid;
    logic                      awready;
    logic [ID_WIDTH-1:0]       awid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [LEN_WIDTH-1:0]      awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;

    logic                      wvalid;
    logic                      wready;
    logic [ID_WIDTH-1:0]       wid;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;

    logic                      bvalid;
    logic                      bready;
    logic [ID_WIDTH-1:0]       bid;
    logic [1:0]                bresp;

    logic                      req_valid;
    logic                      req_ready;
    logic [ID_WIDTH-1:0]       req_id;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [LEN_WIDTH-1:0]      req_len;

    logic                      wd_valid;
    logic                      wd_ready;
    logic [DATA_WIDTH-1:0]     wd_data;
    logic [DATA_WIDTH/8-1:0]   wd_strb;
    logic                      wd_last;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        output req_valid, req_id, req_addr, req_len,
        input  req_ready,
        output wd_valid, wd_data, wd_strb, wd_last,
        input  wd_ready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        input  req_valid, req_id, req_addr, req_len,
        output req_ready,
        input  wd_valid, wd_data, wd_strb, wd_last,
        output wd_ready
    );

endinterface

// File: rtl/axi_wr_frontend_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding the write-data payload.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write data_i (ignored while full)
//   pop_i     : advance the head (ignored while empty)
//   data_o    : current head entry
//   full_o    : no free entry; derived from registered pointers only
//   empty_o   : no valid entry
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push, do_pop;

    // The extra pointer MSB distinguishes full from empty when the low
    // bits coincide: equal MSBs mean empty, differing MSBs mean full.
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer update; simultaneous push and pop both advance, so the
    // occupancy stays the same.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/axi_wr_frontend.sv
// ---------------------------------------------------------------------------
// axi_wr_frontend
// AXI write-side slave front-end of the DDR2 controller. Accepts one burst at
// a time, forwards the AW command as a single scheduler request, buffers the
// W beats in a FIFO for the data path and returns B once every beat has been
// absorbed and the request has been taken.
//   clk, rst : clock, synchronous active-high reset
//   bus      : axi_wr_frontend_if.slave (AW/W/B, scheduler request, data path)
// Optional build macro AXI_WR_PROTO_CHK_EN adds a sticky protocol-error flag
// reported as SLVERR; without it bresp is always OKAY.
// ---------------------------------------------------------------------------
module axi_wr_frontend
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    axi_wr_frontend_if.slave   bus
);

    localparam int STRB_WIDTH    = DATA_WIDTH / 8;
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;

    wr_fe_state_e              state_q, state_d;
    logic [ID_WIDTH-1:0]       id_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      beat_cnt_q;
    logic                      req_pend_q;

    logic                      awready, wready, bvalid;
    logic                      aw_fire, w_fire, b_fire, last_beat;
    logic                      fifo_full, fifo_empty;
    logic [PAYLOAD_WIDTH-1:0]  fifo_head, head_out;

    // The burst end is decided by the beat count, never by wlast.
    assign last_beat = (beat_cnt_q == len_q);
    assign aw_fire   = bus.awvalid && awready;
    assign w_fire    = bus.wvalid && wready;
    assign b_fire    = bvalid && bus.bready;

    // Next-state and handshake outputs. B is held back until the scheduler
    // has taken the request so that command order is never violated.
    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                awready = 1'b1;
                if (bus.awvalid) state_d = DATA;
            end
            DATA: begin
                wready = !fifo_full;
                if (bus.wvalid && !fifo_full && last_beat) state_d = RESP;
            end
            RESP: begin
                bvalid = !req_pend_q;
                if (!req_pend_q && bus.bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, latched command, beat counter and request-pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            req_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_fire) begin
                id_q       <= bus.awid;
                addr_q     <= bus.awaddr;
                len_q      <= bus.awlen;
                beat_cnt_q <= '0;
                req_pend_q <= 1'b1;
            end else begin
                if (w_fire) beat_cnt_q <= beat_cnt_q + 1'b1;
                if (req_pend_q && bus.req_ready) req_pend_q <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PAYLOAD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_fire),
        .pop_i   (bus.wd_ready),
        .data_i  ({bus.wdata, bus.wstrb, last_beat}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Stale storage is masked so the data-path outputs read zero when empty.
    assign head_out     = fifo_empty ? '0 : fifo_head;

    assign bus.awready   = awready;
    assign bus.wready    = wready;
    assign bus.bvalid    = bvalid;
    assign bus.bid       = id_q;
    assign bus.req_valid = req_pend_q;
    assign bus.req_id    = id_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_len   = len_q;
    assign bus.wd_valid  = !fifo_empty;
    assign bus.wd_data   = head_out[PAYLOAD_WIDTH-1 -: DATA_WIDTH];
    assign bus.wd_strb   = head_out[STRB_WIDTH:1];
    assign bus.wd_last   = head_out[0];

`ifdef AXI_WR_PROTO_CHK_EN
    localparam logic [2:0] FULL_SIZE = axsize_for(DATA_WIDTH);

    logic err_q;

    // Sticky protocol error: reserved burst type (2'b11) or narrow size at
    // AW, or a wlast/wid that disagrees with the latched command per beat.
    // Data is forwarded regardless; the error only changes bresp.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (b_fire) begin
            err_q <= 1'b0;
        end else if (aw_fire && (bus.awburst == 2'b11 || bus.awsize != FULL_SIZE)) begin
            err_q <= 1'b1;
        end else if (w_fire && (bus.wlast != last_beat || bus.wid != id_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.bresp = err_q ? RESP_SLVERR : RESP_OKAY;
`else
    logic unused_proto;

    assign unused_proto = ^{bus.wlast, bus.wid, bus.awsize, bus.awburst, b_fire};
    assign bus.bresp    = RESP_OKAY;
`endif

endmodule
